booth_seq_ctrl: RTL and testbench
=================================

// Module: booth_seq_ctrl
// PURPOSE
//  - Multi-cycle sequencer for a signed radix-2 Booth multiplier: one Booth step per clock.
//  - Operands are accepted and the product is returned over valid/ready handshakes.
//  - Sits between the tile's I/O pins (ui_in/uo_out) and the shared Booth step datapath.
//  - Replaces the fully unrolled combinational multiplier with a small area, W-cycle unit.
// PARAMETERS
//  - W  4  operand width in bits, two's complement; legal range W >= 2; product is 2W bits
// PORTS
//  - clk        in   1   single clock; all state updates on rising edge
//  - rst_n      in   1   synchronous, active-low reset
//  - ena        in   1   global enable; when 0, all registers hold their value
//  - in_valid   in   1   operand pair presented
//  - in_ready   out  1   unit idle, can accept; = (state==IDLE) && ena
//  - a          in   W   multiplicand, signed
//  - b          in   W   multiplier, signed
//  - busy       out  1   high in RUN and DONE
//  - out_valid  out  1   product valid; high only in DONE
//  - out_ready  in   1   consumer accepts product
//  - product    out  2W  signed result; registered, stable while out_valid=1
// BEHAVIOUR
//  - Reset: first edge with rst_n=0 sets state=IDLE, A=0, Q=0, q_1=0, count=0, product=0.
//    Hence out_valid=0 and busy=0. Reset mid-operation aborts the operation and drops the operands.
//  - ena=0: FSM, datapath and product all hold; in_ready=0; out_valid keeps its value.
//  - FSM IDLE -> RUN: on an edge with in_valid && in_ready.
//    Loads M = sext(a) to W+1 bits, A = 0 (W+1 bits), Q = b, q_1 = 0, count = 0.
//  - FSM RUN: each enabled edge performs one Booth step on the pair {Q[0], q_1}.
//    10 -> A = A - M; 01 -> A = A + M; 00/11 -> A unchanged.
//    Then {A, Q, q_1} arithmetic-shifts right by 1; count++.
//  - RUN -> DONE: on the edge where count reaches W-1 (the step-W edge). Same edge loads product = {A[W-1:0], Q}.
//  - FSM DONE: out_valid=1 and product is held. DONE -> IDLE on an edge with out_ready && ena.
//  - Latency: operands accepted at edge t; out_valid high after edge t+W.
//  - Throughput: one product per W+2 cycles minimum. Accept is never overlapped with output in the same cycle.
//  - Arithmetic: A is W+1 bits, so a = -2^(W-1) is exact.
//    Every operand pair gives the exact 2W-bit product, including (-2^(W-1))*(-2^(W-1)) = +2^(2W-2).
//    No post-correction term is applied.
//  - in_valid while busy: ignored, because in_ready=0.
//  - out_ready while not DONE: ignored.
//  - Operand inputs a/b are only sampled at accept; later changes have no effect.
// CONFIGURATION
//  - Macro BOOTH_SEQ_MAC_EN.
//  - Defined: adds input acc_clr (1 bit), sampled at accept, and a 2W-bit accumulator register acc (reset 0).
//    On RUN->DONE: acc_n = (acc_clr_latched ? 0 : acc) + raw product; product = acc = acc_n.
//    Addition wraps modulo 2^(2W).
//  - Undefined: no acc_clr port, no accumulator; product = raw Booth result.
// STRUCTURE
//  - Package booth_pkg holds:
//    - state_t enum {IDLE, RUN, DONE}, 2-bit encoding;
//    - localparam function cnt_w(W) = $clog2(W);
//    - Booth pair codes: BOOTH_ADD = 2'b01, BOOTH_SUB = 2'b10.
//  - Sub-module booth_step: combinational, parameter W.
//    in: A, Q, q_1, M. out: next A, Q, q_1 (add/sub plus arithmetic shift).
//    booth_seq_ctrl instantiates it once and owns the FSM, count and registers.
// TESTING
//  - W=4, reset then a=3 b=-2 (0xE) -> out_valid exactly 4 cycles after accept; product=0xFA (-6).
//  - a=-8 b=-8 -> product=0x40 (+64); a=-8 b=7 -> 0xC8 (-56); a=0 b=-1 -> 0x00.
//  - Hold out_ready=0 for 5 cycles in DONE -> product/out_valid stable and in_ready=0.
//    Release -> in_ready=1 one cycle later.
//  - Drop ena for 3 cycles mid-RUN -> total latency grows by exactly 3; result unchanged.
//  - Assert rst_n=0 at step 2 of RUN -> next cycle state IDLE, product=0, busy=0.
//    A new operation then completes correctly.
//  - BOOTH_SEQ_MAC_EN: 2*3 with acc_clr=1 -> product=6; then 2*(-5) with acc_clr=0 -> product=0xFC (-4).
//  - Exhaustive W=4 sweep of 256 operand pairs against a reference signed multiply; random out_ready stalls.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
// The optional accumulator is enabled with the BOOTH_SEQ_MAC_EN macro.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Step counter width; at least one bit so the counter always exists.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w < 2) ? 32'd1 : int'($clog2(w));
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of M into A, then an
// arithmetic right shift of the {A, Q, q_1} chain.
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W:0]   i_a,
  input  logic [W-1:0] i_q,
  input  logic         i_q1,
  input  logic [W:0]   i_m,
  output logic [W:0]   o_a,
  output logic [W-1:0] o_q,
  output logic         o_q1
);

  logic [W:0] w_sum;

  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_q1})
      BOOTH_SUB: w_sum = i_a - i_m;
      BOOTH_ADD: w_sum = i_a + i_m;
      default:   w_sum = i_a;
    endcase
  end

  assign o_a  = {w_sum[W], w_sum[W:1]};
  assign o_q  = {w_sum[0], i_q[W-1:1]};
  assign o_q1 = i_q[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencer for a signed radix-2 Booth multiplier, one step per enabled clock.
// Defining BOOTH_SEQ_MAC_EN adds the acc_clr input and a wrapping 2W-bit accumulator.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
`ifdef BOOTH_SEQ_MAC_EN
  input  logic           acc_clr,
`endif
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product
);

  localparam int unsigned CntW = cnt_w(W);

  state_t            r_state;
  logic [W:0]        r_a;
  logic [W:0]        r_m;
  logic [W-1:0]      r_q;
  logic              r_q1;
  logic [CntW-1:0]   r_count;
  logic [2*W-1:0]    r_product;

  logic [W:0]        w_a_nx;
  logic [W-1:0]      w_q_nx;
  logic              w_q1_nx;
  logic [2*W-1:0]    w_raw;
  logic [2*W-1:0]    w_result;
  logic              w_last;

  booth_step #(
    .W(W)
  ) u_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_a_nx),
    .o_q  (w_q_nx),
    .o_q1 (w_q1_nx)
  );

  // A carries one guard bit, so the low W bits of A above Q form the exact product.
  assign w_raw  = {w_a_nx[W-1:0], w_q_nx};
  assign w_last = (r_count == CntW'(W - 1));

`ifdef BOOTH_SEQ_MAC_EN
  logic [2*W-1:0] r_acc;
  logic           r_acc_clr;

  assign w_result = (r_acc_clr ? '0 : r_acc) + w_raw;
`else
  assign w_result = w_raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
`ifdef BOOTH_SEQ_MAC_EN
      r_acc     <= '0;
      r_acc_clr <= 1'b0;
`endif
    end else if (ena) begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_m     <= {a[W-1], a};
            r_a     <= '0;
            r_q     <= b;
            r_q1    <= 1'b0;
            r_count <= '0;
            r_state <= RUN;
`ifdef BOOTH_SEQ_MAC_EN
            r_acc_clr <= acc_clr;
`endif
          end
        end
        RUN: begin
          r_a     <= w_a_nx;
          r_q     <= w_q_nx;
          r_q1    <= w_q1_nx;
          r_count <= r_count + CntW'(1);
          if (w_last) begin
            r_product <= w_result;
`ifdef BOOTH_SEQ_MAC_EN
            r_acc     <= w_result;
`endif
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && ena;
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign out_valid = (r_state == DONE);
  assign product   = r_product;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (W=4); covers the BOOTH_SEQ_MAC_EN build when defined.
module tb_booth_seq_ctrl;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           ena;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           acc_clr;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;
  logic           mon_en = 1'b0;
  logic [2*W-1:0] exp_prod;
  logic [2*W-1:0] m_acc;

  booth_seq_ctrl #(
    .W(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef BOOTH_SEQ_MAC_EN
    .acc_clr   (acc_clr),
`endif
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int xi;
    int yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    return (2*W)'(xi * yi);
  endfunction

  // Output checker: whenever a product is offered it must match the model.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_valid) chk("cmp_product", product, exp_prod);
      chk("cmp_in_ready", in_ready, !busy && ena);
      chk("cmp_valid_busy", out_valid && !busy, 1'b0);
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic clr,
                        input int gap_at, input int gap_len, input int hold,
                        output logic [2*W-1:0] prod, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_ready", in_ready, 1'b1);
    m_acc = (clr ? '0 : m_acc) + model_mul(ta, tb);
`ifdef BOOTH_SEQ_MAC_EN
    exp_prod = m_acc;
`else
    exp_prod = model_mul(ta, tb);
`endif
    a = ta;
    b = tb;
    acc_clr = clr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    acc_clr = ~clr;
    chk("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      ena = !(lat >= gap_at && lat < gap_at + gap_len);
      @(posedge clk); #1;
      lat++;
    end
    ena = 1'b1;
    chk("done_seen", out_valid, 1'b1);
    prod = product;
    repeat (hold) begin
      chk("hold_in_ready", in_ready, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_product", product, prod);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_idle", {out_valid, busy, in_ready}, 3'b001);
  endtask

  initial begin
    logic [2*W-1:0] p;
    int lat;
    rst_n = 1'b0;
    ena = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    acc_clr = 1'b0;
    m_acc = '0;
    exp_prod = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_product", product, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_op(4'd3, 4'hE, 1'b1, 99, 0, 0, p, lat);
    chk("lat_3x-2", lat, W);
    chk("p_3x-2", p, 8'hFA);
    run_op(4'h8, 4'h8, 1'b1, 99, 0, 0, p, lat);
    chk("p_-8x-8", p, 8'h40);
    run_op(4'h8, 4'h7, 1'b1, 99, 0, 0, p, lat);
    chk("p_-8x7", p, 8'hC8);
    run_op(4'h0, 4'hF, 1'b1, 99, 0, 0, p, lat);
    chk("p_0x-1", p, 8'h00);

    // Consumer stall in DONE.
    run_op(4'd5, 4'd3, 1'b1, 99, 0, 5, p, lat);
    chk("p_5x3_hold", p, 8'h0F);

    // Enable dropped for three cycles mid-run.
    run_op(4'hB, 4'd6, 1'b1, 1, 3, 0, p, lat);
    chk("lat_ena_gap", lat, W + 3);
    chk("p_-5x6_gap", p, 8'hE2);

    // Reset during the second step aborts the operation.
    a = 4'd6;
    b = 4'd5;
    acc_clr = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_acc = '0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_product", product, 8'h00);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    run_op(4'd7, 4'hF, 1'b1, 99, 0, 0, p, lat);
    chk("p_7x-1_after_abort", p, 8'hF9);

`ifdef BOOTH_SEQ_MAC_EN
    run_op(4'd2, 4'd3, 1'b1, 99, 0, 0, p, lat);
    chk("mac_clr_2x3", p, 8'h06);
    run_op(4'd2, 4'hB, 1'b0, 99, 0, 0, p, lat);
    chk("mac_acc_2x-5", p, 8'hFC);
`endif

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(W'(i), W'(j), 1'b1, 99, 0, int'($urandom_range(0, 2)), p, lat);
        chk("sweep_lat", lat, W);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
